sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 27 ++
 rtl/sync_fifo_if.sv | 37 +++
 rtl/sync_fifo_ram.sv | 40 ++++
 rtl/sync_fifo.sv | 159 +++++++++++++++
 tb/tb_sync_fifo.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg -- shared definitions for the FIFO blocks.
//   clog2      : width helper, ceil(log2(value)) for value >= 1
//   OVF_BIT    : position of the overflow flag in the sticky error vector
//   UDF_BIT    : position of the underflow flag in the sticky error vector
//   ERR_BITS   : width of the sticky error vector
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int OVF_BIT  = 0;
  localparam int UDF_BIT  = 1;
  localparam int ERR_BITS = 2;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if -- handshake/status bundle of sync_fifo.
//   master : the FIFO user (drives write/din/read/err_clr)
//   slave  : the FIFO itself (drives data, occupancy and flag outputs)
// Parameters: DWIDTH data width, DEPTH storage depth (power of two).
// -----------------------------------------------------------------------------
interface sync_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
);

  localparam int AWIDTH = fifo_pkg::clog2(DEPTH);

  logic              write;
  logic [DWIDTH-1:0] din;
  logic              full;
  logic              almost_full;
  logic              read;
  logic [DWIDTH-1:0] dout;
  logic              empty;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output write, din, read, err_clr,
    input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write, din, read, err_clr,
    output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram -- simple dual-port storage, DWIDTH x DEPTH, no reset.
//   clk   : clock
//   we    : write enable,  waddr/wdata : write address/data
//   re    : read enable,   raddr       : read address
//   rdata : registered read data, updated only on cycles with re=1
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  localparam int AWIDTH = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_r [DEPTH];

  // Write port: store the word on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered read, holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with occupancy, almost flags and sticky
// overflow/underflow error flags.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sync_fifo_if.slave (write/din/read/err_clr in; dout, full,
//         almost_full, empty, almost_empty, count, overflow, underflow out)
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through, where dout
// always shows the head word while not empty. Without it, dout is updated one
// cycle after an accepted read and holds otherwise.
// -----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRES  = 4,
  parameter int AEMPTY_THRES = 4
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int AWIDTH = clog2(DEPTH);
  localparam logic [AWIDTH:0]   DEPTH_W    = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AFULL_LVL  = (AWIDTH+1)'(DEPTH - AFULL_THRES);
  localparam logic [AWIDTH:0]   AEMPTY_LVL = (AWIDTH+1)'(AEMPTY_THRES);
  localparam logic [AWIDTH:0]   PTR_ONE    = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   PTR_ZERO   = {(AWIDTH+1){1'b0}};
  localparam logic [DWIDTH-1:0] DATA_ZERO  = {DWIDTH{1'b0}};

  logic [AWIDTH:0]     wrptr_r, rdptr_r;
  logic [AWIDTH:0]     wrptr_next_s, rdptr_next_s;
  logic [AWIDTH:0]     count_s;
  logic                full_s, empty_s;
  logic                wen_s, ren_s;
  logic [ERR_BITS-1:0] err_r, err_next_s;
  logic                ram_re_s;
  logic [AWIDTH-1:0]   ram_raddr_s;
  logic [DWIDTH-1:0]   ram_q_s;

  // The extra pointer bit distinguishes full from empty on equal addresses.
  assign count_s = wrptr_r - rdptr_r;
  assign full_s  = (count_s == DEPTH_W);
  assign empty_s = (count_s == PTR_ZERO);
  assign wen_s   = bus.write && !full_s;
  assign ren_s   = bus.read && !empty_s;

  // Next pointer values from the accepted push/pop.
  always_comb begin
    wrptr_next_s = wrptr_r;
    rdptr_next_s = rdptr_r;
    if (wen_s) begin
      wrptr_next_s = wrptr_r + PTR_ONE;
    end else begin
      wrptr_next_s = wrptr_r;
    end
    if (ren_s) begin
      rdptr_next_s = rdptr_r + PTR_ONE;
    end else begin
      rdptr_next_s = rdptr_r;
    end
  end

  // A new offending request wins over err_clr in the same cycle.
  always_comb begin
    err_next_s          = err_r;
    err_next_s[OVF_BIT] = (bus.write && full_s)  || (err_r[OVF_BIT] && !bus.err_clr);
    err_next_s[UDF_BIT] = (bus.read  && empty_s) || (err_r[UDF_BIT] && !bus.err_clr);
  end

  // Pointer and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr_r <= PTR_ZERO;
      rdptr_r <= PTR_ZERO;
      err_r   <= {ERR_BITS{1'b0}};
    end else begin
      wrptr_r <= wrptr_next_s;
      rdptr_r <= rdptr_next_s;
      err_r   <= err_next_s;
    end
  end

  sync_fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wen_s),
    .waddr (wrptr_r[AWIDTH-1:0]),
    .wdata (bus.din),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_q_s)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM continuously prefetches the word that will be at the head after
  // this cycle. When that word is the one being written right now, the RAM
  // cannot return it yet, so it is captured in a bypass register instead.
  logic [AWIDTH:0]   count_next_s;
  logic              byp_next_s;
  logic              byp_r;
  logic [DWIDTH-1:0] byp_data_r;
  logic              head_ok_r;

  assign ram_re_s     = 1'b1;
  assign ram_raddr_s  = rdptr_next_s[AWIDTH-1:0];
  assign count_next_s = wrptr_next_s - rdptr_next_s;
  assign byp_next_s   = wen_s && (rdptr_next_s == wrptr_r);

  // Head-word source selection state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_r      <= 1'b0;
      byp_data_r <= DATA_ZERO;
      head_ok_r  <= 1'b0;
    end else begin
      byp_r      <= byp_next_s;
      byp_data_r <= bus.din;
      head_ok_r  <= !byp_next_s && (count_next_s != PTR_ZERO);
    end
  end

  assign bus.dout = byp_r ? byp_data_r : (head_ok_r ? ram_q_s : DATA_ZERO);
`else
  // RAM output only becomes meaningful after the first accepted read;
  // before that (and after reset) dout reads as zero.
  logic dout_vld_r;

  assign ram_re_s    = ren_s;
  assign ram_raddr_s = rdptr_r[AWIDTH-1:0];

  // Marks that the RAM read register holds a popped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_vld_r <= 1'b0;
    end else if (ren_s) begin
      dout_vld_r <= 1'b1;
    end else begin
      dout_vld_r <= dout_vld_r;
    end
  end

  assign bus.dout = dout_vld_r ? ram_q_s : DATA_ZERO;
`endif

  // Flags are decoded from the registered pointers only.
  assign bus.count        = count_s;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_s >= AFULL_LVL);
  assign bus.almost_empty = (count_s <= AEMPTY_LVL);
  assign bus.overflow     = err_r[OVF_BIT];
  assign bus.underflow    = err_r[UDF_BIT];

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo -- directed self-checking bench for sync_fifo (DEPTH=16,
// DWIDTH=32, AFULL_THRES=4, AEMPTY_THRES=4). Standard-mode scenarios run by
// default; the first-word-fall-through scenario runs when SYNC_FIFO_FWFT_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW = 32;
  localparam int DP = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sync_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();

  sync_fifo #(
    .DWIDTH       (DW),
    .DEPTH        (DP),
    .AFULL_THRES  (4),
    .AEMPTY_THRES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abort guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.err_clr = 1'b0;
    bus.din     = 32'h0;
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b/%b exp=1/1", bus.empty, bus.almost_empty); end
    total++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b/%b exp=0/0", bus.full, bus.almost_full); end
    total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", bus.overflow, bus.underflow); end
    total++; if (bus.dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_fill();
    logic [4:0] exp_c;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.write = 1'b1;
      bus.din   = 32'(i);
      cycle();
      exp_c = 5'(i + 1);
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c); end
      total++; if (bus.almost_full !== (exp_c >= 5'd12)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.almost_full, exp_c >= 5'd12); end
      total++; if (bus.full !== (exp_c == 5'd16)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, exp_c == 5'd16); end
      total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, bus.empty); end
    end
    bus.din = 32'hFF;
    cycle();
    bus.write = 1'b0;
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin bad++; $display("FAIL fill_ovf_count got=%0d/%b exp=16/1", bus.count, bus.full); end
  endtask

  task automatic test_drain();
    logic [4:0] exp_c;
    for (int i = 0; i < 16; i++) begin
      bus.read = 1'b1;
      cycle();
      exp_c = 5'(15 - i);
      total++; if (bus.dout !== 32'(i)) begin bad++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, bus.dout, 32'(i)); end
      total++; if (bus.count !== exp_c) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c); end
      total++; if (bus.empty !== (exp_c == 5'd0)) begin bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, bus.empty, exp_c == 5'd0); end
      total++; if (bus.almost_empty !== (exp_c <= 5'd4)) begin bad++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, bus.almost_empty, exp_c <= 5'd4); end
    end
    cycle();
    total++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b1) begin bad++; $display("FAIL drain_flags got=%b/%b exp=1/1", bus.underflow, bus.overflow); end
    total++; if (bus.dout !== 32'h0F || bus.count !== 5'd0) begin bad++; $display("FAIL drain_hold got=%h/%0d exp=f/0", bus.dout, bus.count); end
    bus.err_clr = 1'b1;
    cycle();
    total++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_vs_set got=%b/%b exp=1/0", bus.underflow, bus.overflow); end
    bus.read = 1'b0;
    cycle();
    bus.err_clr = 1'b0;
    total++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL err_clr got=%b/%b exp=0/0", bus.underflow, bus.overflow); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.write = 1'b1;
      bus.din   = 32'h100 + 32'(i);
      cycle();
    end
    for (int k = 0; k < 40; k++) begin
      bus.write = 1'b1;
      bus.read  = 1'b1;
      bus.din   = 32'h108 + 32'(k);
      cycle();
      total++; if (bus.count !== 5'd8) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=8", k, bus.count); end
      total++; if (bus.dout !== 32'h100 + 32'(k)) begin bad++; $display("FAIL stream_dout[%0d] got=%h exp=%h", k, bus.dout, 32'h100 + 32'(k)); end
    end
    idle();
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.write = 1'b1;
      bus.din   = 32'h200 + 32'(i);
      cycle();
    end
    bus.read = 1'b1;
    bus.din  = 32'hDEAD;
    cycle();
    total++; if (bus.count !== 5'd15 || bus.overflow !== 1'b1) begin bad++; $display("FAIL simul_full got=%0d/%b exp=15/1", bus.count, bus.overflow); end
    total++; if (bus.dout !== 32'h200) begin bad++; $display("FAIL simul_full_dout got=%h exp=200", bus.dout); end
    bus.write = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle();
    end
    total++; if (bus.dout !== 32'h20F || bus.count !== 5'd0) begin bad++; $display("FAIL simul_drain got=%h/%0d exp=20f/0", bus.dout, bus.count); end
    idle();
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    bus.write   = 1'b1;
    bus.read    = 1'b1;
    bus.din     = 32'h77;
    cycle();
    total++; if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL simul_empty got=%0d/%b/%b exp=1/1/0", bus.count, bus.underflow, bus.overflow); end
    bus.write = 1'b0;
    cycle();
    bus.read = 1'b0;
    total++; if (bus.dout !== 32'h77 || bus.empty !== 1'b1) begin bad++; $display("FAIL simul_readback got=%h/%b exp=77/1", bus.dout, bus.empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.read = 1'b1;
    cycle();
    bus.read = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.write = 1'b1;
      bus.din   = 32'h300 + 32'(i);
      cycle();
    end
    bus.write = 1'b0;
    bus.read  = 1'b1;
    cycle();
    total++; if (bus.count !== 5'd10 || bus.dout !== 32'h300 || bus.underflow !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%h/%b exp=10/300/1", bus.count, bus.dout, bus.underflow); end
    bus.read  = 1'b0;
    bus.write = 1'b1;
    bus.din   = 32'h30B;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_count got=%0d/%b/%b exp=0/1/1", bus.count, bus.empty, bus.almost_empty); end
    total++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b%b%b exp=0000", bus.full, bus.almost_full, bus.underflow, bus.overflow); end
    total++; if (bus.dout !== 32'h0) begin bad++; $display("FAIL mid_rst_dout got=%h exp=0", bus.dout); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    bus.write = 1'b1;
    bus.din   = 32'h55;
    cycle();
    bus.write = 1'b0;
    bus.read  = 1'b1;
    cycle();
    bus.read = 1'b0;
    total++; if (bus.dout !== 32'h55 || bus.count !== 5'd0) begin bad++; $display("FAIL mid_post got=%h/%0d exp=55/0", bus.dout, bus.count); end
  endtask

  task automatic test_fwft();
    do_reset();
    bus.write = 1'b1;
    bus.din   = 32'hA5;
    cycle();
    bus.write = 1'b0;
    total++; if (bus.empty !== 1'b0 || bus.dout !== 32'hA5 || bus.count !== 5'd1) begin bad++; $display("FAIL fwft_first got=%b/%h/%0d exp=0/a5/1", bus.empty, bus.dout, bus.count); end
    cycle();
    total++; if (bus.dout !== 32'hA5) begin bad++; $display("FAIL fwft_hold got=%h exp=a5", bus.dout); end
    bus.write = 1'b1;
    bus.din   = 32'h11;
    cycle();
    bus.din   = 32'h22;
    cycle();
    bus.write = 1'b0;
    total++; if (bus.dout !== 32'hA5 || bus.count !== 5'd3) begin bad++; $display("FAIL fwft_queue got=%h/%0d exp=a5/3", bus.dout, bus.count); end
    bus.read = 1'b1;
    cycle();
    total++; if (bus.dout !== 32'h11 || bus.count !== 5'd2) begin bad++; $display("FAIL fwft_pop1 got=%h/%0d exp=11/2", bus.dout, bus.count); end
    cycle();
    total++; if (bus.dout !== 32'h22 || bus.count !== 5'd1) begin bad++; $display("FAIL fwft_pop2 got=%h/%0d exp=22/1", bus.dout, bus.count); end
    cycle();
    bus.read = 1'b0;
    total++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin bad++; $display("FAIL fwft_empty got=%b/%0d exp=1/0", bus.empty, bus.count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();
    test_reset();
    test_fill();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`else
    test_drain();
    test_stream();
    test_simul();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
